// File: rtl/a51_pkg.sv
// a51_pkg: shared state encoding and sizing for the keystream XOR serializer
package a51_pkg;
    localparam int KS_BITS_DEF = 128;
    localparam int NIB_W_DEF   = 4;
    localparam int NIBBLES     = KS_BITS_DEF / NIB_W_DEF;

    typedef enum logic [2:0] {
        IDLE,
        COLLECT,
        XOR,
        SEND,
        DONE
    } state_e;
endpackage

// File: rtl/keystream_capture_reg.sv
// keystream_capture_reg: MSB-first serial capture of keystream bits with fill count and end detect
module keystream_capture_reg #(
    parameter int KS_BITS = 128
) (
    input  logic               clk,
    input  logic               clrn,
    input  logic               clear,
    input  logic               en,
    input  logic               ks_valid,
    input  logic               ks_bit,
    input  logic               ks_done,
    output logic [KS_BITS-1:0] ks_reg,
    output logic [7:0]         bit_count,
    output logic               full,
    output logic               early_end
);
    localparam int IW = $clog2(KS_BITS);
    localparam logic [7:0] FULL_CNT = 8'(KS_BITS);

    logic [KS_BITS-1:0] ks_q, ks_d;
    logic [7:0]         cnt_q, cnt_d;
    logic               cap;
    logic [IW-1:0]      idx;

    // Capture one bit per valid cycle at the slot given by arrival order; the
    // early-end check sees the count including a bit captured this cycle.
    always_comb begin
        cap = en && ks_valid && (cnt_q != FULL_CNT);
        idx = IW'(KS_BITS - 1) - cnt_q[IW-1:0];
        ks_d = clear ? '0 : ks_q;
        cnt_d = clear ? '0 : cnt_q;
        if (!clear && cap) begin
            ks_d[idx] = ks_bit;
            cnt_d = cnt_q + 8'd1;
        end
        full = cap && (cnt_d == FULL_CNT);
        early_end = en && !clear && ks_done && (cnt_d != FULL_CNT);
    end

    // Capture register and bit counter
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            ks_q  <= '0;
            cnt_q <= '0;
        end else begin
            ks_q  <= ks_d;
            cnt_q <= cnt_d;
        end
    end

    assign ks_reg    = ks_q;
    assign bit_count = cnt_q;
endmodule

// File: rtl/keystream_xor_serializer.sv
// keystream_xor_serializer: captures keystream, XORs with message, streams nibbles MSN first
module keystream_xor_serializer
    import a51_pkg::*;
#(
    parameter int KS_BITS = KS_BITS_DEF,
    parameter int NIB_W   = NIB_W_DEF
) (
    input  logic               clk,
    input  logic               clrn,
    input  logic               start,
    input  logic               ks_valid,
    input  logic               ks_bit,
    input  logic               ks_done,
    input  logic [KS_BITS-1:0] data_in,
    output logic [NIB_W-1:0]   out_nibble,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               busy,
    output logic               done,
    output logic               short_err,
    output logic [7:0]         bit_count
);
    localparam int NIB_CNT = KS_BITS / NIB_W;
    localparam int NW = $clog2(NIB_CNT);
    localparam logic [NW-1:0] LAST_NIB = NW'(NIB_CNT - 1);

    state_e             state_q, state_d;
    logic [KS_BITS-1:0] xor_q, xor_d;
    logic [NW-1:0]      nib_q, nib_d;
    logic               short_q, short_d;
    logic [KS_BITS-1:0] ks_reg;
    logic               cap_full, early_end;
    logic [NIB_W-1:0]   nibs [NIB_CNT];

    keystream_capture_reg #(.KS_BITS(KS_BITS)) u_cap (
        .clk       (clk),
        .clrn      (clrn),
        .clear     (start),
        .en        (state_q == COLLECT && !start),
        .ks_valid  (ks_valid),
        .ks_bit    (ks_bit),
        .ks_done   (ks_done),
        .ks_reg    (ks_reg),
        .bit_count (bit_count),
        .full      (cap_full),
        .early_end (early_end)
    );

    // State register
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next state: start overrides everything, otherwise advance through the phases
    always_comb begin
        state_d = state_q;
        if (start) state_d = COLLECT;
        else begin
            case (state_q)
                COLLECT: if (cap_full || early_end) state_d = XOR;
                XOR:     state_d = SEND;
                SEND:    if (out_ready && nib_q == LAST_NIB) state_d = DONE;
                default: state_d = state_q;
            endcase
        end
    end

    // Datapath next values: XOR load, nibble index advance on transfer, sticky short flag
    always_comb begin
        xor_d = (state_q == XOR) ? (ks_reg ^ data_in) : xor_q;
        nib_d = (start || state_q == XOR) ? '0 :
                (state_q == SEND && out_ready) ? nib_q + NW'(1) : nib_q;
        short_d = start ? 1'b0 : (early_end ? 1'b1 : short_q);
    end

    // Datapath registers
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            xor_q   <= '0;
            nib_q   <= '0;
            short_q <= 1'b0;
        end else begin
            xor_q   <= xor_d;
            nib_q   <= nib_d;
            short_q <= short_d;
        end
    end

    // Outputs decoded from state and registers only; nibble 0 is the top of xor_q
    always_comb begin
        for (int i = 0; i < NIB_CNT; i++) nibs[i] = xor_q[KS_BITS-1-NIB_W*i -: NIB_W];
        out_valid  = (state_q == SEND);
        out_nibble = out_valid ? nibs[nib_q] : '0;
        busy       = (state_q == COLLECT) || (state_q == XOR) || (state_q == SEND);
        done       = (state_q == DONE);
        short_err  = short_q;
    end
endmodule

// File: tb/tb_keystream_xor_serializer.sv
// tb_keystream_xor_serializer: directed self-checking bench for the keystream XOR serializer
module tb_keystream_xor_serializer;
    logic         clk = 0;
    logic         clrn = 0;
    logic         start = 0;
    logic         ks_valid = 0;
    logic         ks_bit = 0;
    logic         ks_done = 0;
    logic [127:0] data_in = '0;
    logic [3:0]   out_nibble;
    logic         out_valid;
    logic         out_ready = 0;
    logic         busy;
    logic         done;
    logic         short_err;
    logic [7:0]   bit_count;

    int           pass_cnt = 0;
    int           chk_cnt = 0;
    logic [127:0] acc;
    bit           tmo;

    keystream_xor_serializer dut (
        .clk        (clk),
        .clrn       (clrn),
        .start      (start),
        .ks_valid   (ks_valid),
        .ks_bit     (ks_bit),
        .ks_done    (ks_done),
        .data_in    (data_in),
        .out_nibble (out_nibble),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .busy       (busy),
        .done       (done),
        .short_err  (short_err),
        .bit_count  (bit_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1;
        tick();
        start = 0;
    endtask

    // mode 0: zeros, 1: ones, 2: alternating starting with 1
    task automatic feed(input int n, input int mode);
        for (int i = 0; i < n; i++) begin
            ks_valid = 1;
            ks_bit = (mode == 1) || (mode == 2 && i % 2 == 0);
            tick();
        end
        ks_valid = 0;
        ks_bit = 0;
    endtask

    task automatic recv(input int n);
        out_ready = 1;
        for (int i = 0; i < n; i++) begin
            int w = 0;
            while (!out_valid && w < 20) begin
                tick();
                w++;
            end
            if (!out_valid) tmo = 1;
            acc = {acc[123:0], out_nibble};
            tick();
        end
        out_ready = 0;
    endtask

    task automatic test_reset();
        chk_cnt++;
        if ({out_valid, busy, done, short_err, bit_count, out_nibble} !== 16'h0)
            $display("FAIL reset_outputs: got v=%b b=%b d=%b s=%b cnt=%0d nib=%h want all 0",
                     out_valid, busy, done, short_err, bit_count, out_nibble);
        else pass_cnt++;
        tick();
        clrn = 1;
        tick();
        chk_cnt++;
        if (busy !== 1'b0 || done !== 1'b0) $display("FAIL reset_idle: busy=%b done=%b want 0 0", busy, done);
        else pass_cnt++;
    endtask

    task automatic test_all_ones();
        data_in = 128'h0123456789ABCDEF_FEDCBA9876543210;
        pulse_start();
        chk_cnt++;
        if (busy !== 1'b1 || bit_count !== 8'd0) $display("FAIL collect_entry: busy=%b cnt=%0d want 1 0", busy, bit_count);
        else pass_cnt++;
        feed(128, 1);
        chk_cnt++;
        if (bit_count !== 8'd128 || out_valid !== 1'b0 || busy !== 1'b1)
            $display("FAIL xor_state: cnt=%0d v=%b busy=%b want 128 0 1", bit_count, out_valid, busy);
        else pass_cnt++;
        tick();
        chk_cnt++;
        if (out_valid !== 1'b1 || out_nibble !== 4'hF) $display("FAIL first_nibble: v=%b nib=%h want 1 f", out_valid, out_nibble);
        else pass_cnt++;
        acc = '0;
        tmo = 0;
        recv(32);
        chk_cnt++;
        if (tmo || acc !== 128'hFEDCBA9876543210_0123456789ABCDEF)
            $display("FAIL ones_stream: got %h tmo=%b want fedcba98765432100123456789abcdef", acc, tmo);
        else pass_cnt++;
        chk_cnt++;
        if (done !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || short_err !== 1'b0)
            $display("FAIL ones_done: done=%b v=%b busy=%b short=%b want 1 0 0 0", done, out_valid, busy, short_err);
        else pass_cnt++;
    endtask

    task automatic test_zero_ks();
        data_in = 128'hDEADBEEF_00000000_00000000_CAFEF00D;
        pulse_start();
        feed(128, 0);
        acc = '0;
        tmo = 0;
        recv(32);
        chk_cnt++;
        if (tmo || acc !== 128'hDEADBEEF_00000000_00000000_CAFEF00D)
            $display("FAIL zero_ks_stream: got %h tmo=%b want deadbeef0000000000000000cafef00d", acc, tmo);
        else pass_cnt++;
        chk_cnt++;
        if (done !== 1'b1) $display("FAIL zero_ks_done: done=%b want 1", done);
        else pass_cnt++;
    endtask

    task automatic test_alternating_stall();
        data_in = '0;
        pulse_start();
        feed(128, 2);
        acc = '0;
        tmo = 0;
        recv(3);
        for (int i = 0; i < 5; i++) begin
            chk_cnt++;
            if (out_valid !== 1'b1 || out_nibble !== 4'hA)
                $display("FAIL stall_hold[%0d]: v=%b nib=%h want 1 a", i, out_valid, out_nibble);
            else pass_cnt++;
            tick();
        end
        recv(28);
        chk_cnt++;
        if (done !== 1'b0 || out_valid !== 1'b1) $display("FAIL stall_count: done=%b v=%b want 0 1 before last nibble", done, out_valid);
        else pass_cnt++;
        recv(1);
        chk_cnt++;
        if (tmo || acc !== {32{4'hA}} || done !== 1'b1)
            $display("FAIL alt_stream: got %h tmo=%b done=%b want all a, done 1", acc, tmo, done);
        else pass_cnt++;
    endtask

    task automatic test_short();
        data_in = '0;
        pulse_start();
        feed(40, 1);
        ks_done = 1;
        tick();
        ks_done = 0;
        chk_cnt++;
        if (short_err !== 1'b1 || bit_count !== 8'd40)
            $display("FAIL short_flag: short=%b cnt=%0d want 1 40", short_err, bit_count);
        else pass_cnt++;
        acc = '0;
        tmo = 0;
        recv(32);
        chk_cnt++;
        if (tmo || acc !== 128'hFFFFFFFFFF_0000000000000000000000)
            $display("FAIL short_stream: got %h tmo=%b want ffffffffff0000000000000000000000", acc, tmo);
        else pass_cnt++;
        chk_cnt++;
        if (done !== 1'b1 || short_err !== 1'b1) $display("FAIL short_done: done=%b short=%b want 1 1", done, short_err);
        else pass_cnt++;
    endtask

    task automatic test_start_during_send();
        data_in = '0;
        pulse_start();
        chk_cnt++;
        if (short_err !== 1'b0) $display("FAIL start_clears_short: short=%b want 0", short_err);
        else pass_cnt++;
        feed(128, 1);
        acc = '0;
        tmo = 0;
        recv(7);
        chk_cnt++;
        if (out_valid !== 1'b1 || done !== 1'b0) $display("FAIL mid_send: v=%b done=%b want 1 0", out_valid, done);
        else pass_cnt++;
        ks_valid = 1;
        ks_bit = 1;
        pulse_start();
        ks_valid = 0;
        chk_cnt++;
        if (out_valid !== 1'b0 || busy !== 1'b1 || bit_count !== 8'd0 || short_err !== 1'b0)
            $display("FAIL restart: v=%b busy=%b cnt=%0d short=%b want 0 1 0 0", out_valid, busy, bit_count, short_err);
        else pass_cnt++;
        feed(128, 1);
        feed(6, 1);
        chk_cnt++;
        if (bit_count !== 8'd128 || out_valid !== 1'b1)
            $display("FAIL no_wrap: cnt=%0d v=%b want 128 1", bit_count, out_valid);
        else pass_cnt++;
    endtask

    task automatic test_async_reset();
        pulse_start();
        feed(60, 1);
        chk_cnt++;
        if (bit_count !== 8'd60) $display("FAIL pre_reset_count: cnt=%0d want 60", bit_count);
        else pass_cnt++;
        @(negedge clk);
        clrn = 0;
        #1;
        chk_cnt++;
        if ({out_valid, busy, done, short_err, bit_count, out_nibble} !== 16'h0)
            $display("FAIL async_reset: v=%b busy=%b done=%b short=%b cnt=%0d nib=%h want all 0",
                     out_valid, busy, done, short_err, bit_count, out_nibble);
        else pass_cnt++;
        tick();
        clrn = 1;
        feed(10, 1);
        chk_cnt++;
        if (bit_count !== 8'd0 || busy !== 1'b0) $display("FAIL idle_ignore: cnt=%0d busy=%b want 0 0", bit_count, busy);
        else pass_cnt++;
    endtask

    initial begin
        #1;
        test_reset();
        test_all_ones();
        test_zero_ks();
        test_alternating_stall();
        test_short();
        test_start_during_send();
        test_async_reset();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
